fsm_control: RTL and testbench

Sequencing controller for the 8×8 two-dimensional DCT datapath of the MPEG block.
- After a Start pulse it walks every output coefficient (u,v) and every input pixel (x,y) of the block.
- For each pixel it addresses the pixel memory, issues a read, waits for the data, then fires one MAC-enable pulse.
- A full run produces exactly 4096 MAC pulses (64 coefficients × 64 pixels), then Ready is raised.
- It sits between the pixel RAM (Address/Read_Enable) and the multiply-accumulate/cosine-ROM datapath (var_u/v/x/y, Active_MAC).

---
 rtl/fsm_control_pkg.sv | 26 ++
 rtl/dct_index_counter.sv | 37 +++
 rtl/fsm_control.sv | 84 ++++++++
 tb/tb_fsm_control.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_control_pkg.sv
// Shared types and constants for the 8x8 DCT sequencing controller.
// Exports state_e (fixed encodings), dct_idx_t and block-size constants.
package fsm_control_pkg;

  localparam int DCT_N  = 8;
  localparam int IDX_W  = $clog2(DCT_N);
  localparam int ADDR_W = 2 * IDX_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_ADDR = 3'd1,
    ACT_RE    = 3'd2,
    WAIT_DATA = 3'd3,
    ACCUM     = 3'd4,
    DONE      = 3'd5
  } state_e;

  // Field order makes a plain +1 cascade x -> y -> v -> u.
  typedef struct packed {
    logic [IDX_W-1:0] u;
    logic [IDX_W-1:0] v;
    logic [IDX_W-1:0] y;
    logic [IDX_W-1:0] x;
  } dct_idx_t;

endpackage

// File: rtl/dct_index_counter.sv
// Four cascaded 3-bit (u,v,y,x) counters, x fastest, u slowest.
// Ports: clk, rst_n, clr (sync clear), inc, idx (counters), all_max.
module dct_index_counter
  import fsm_control_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  input  logic     inc,
  output dct_idx_t idx,
  output logic     all_max
);

  dct_idx_t idx_q;
  dct_idx_t idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = dct_idx_t'(idx_q + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx     = idx_q;
  assign all_max = &idx_q;

endmodule

// File: rtl/fsm_control.sv
// DCT sequencer: walks (u,v,x,y), strobes RAM reads, pulses the MAC.
// Ports: Clock, Reset (async low), Start -> var_u/v/x/y, Address,
// Read_Enable, Active_MAC, Ready. FSM_CONTROL_WAIT_STATE_EN adds WAIT_DATA.
module fsm_control
  import fsm_control_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic [IDX_W-1:0]  var_u,
  output logic [IDX_W-1:0]  var_v,
  output logic [IDX_W-1:0]  var_x,
  output logic [IDX_W-1:0]  var_y,
  output logic [ADDR_W-1:0] Address,
  output logic              Read_Enable,
  output logic              Active_MAC,
  output logic              Ready
);

  state_e   state_q;
  state_e   state_d;
  logic     idx_clr;
  logic     idx_inc;
  logic     all_max;
  dct_idx_t idx;

  always_comb begin
    state_d = state_q;
    idx_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = SEND_ADDR;
          idx_clr = 1'b1;
        end
      end
      SEND_ADDR: state_d = ACT_RE;
`ifdef FSM_CONTROL_WAIT_STATE_EN
      ACT_RE:    state_d = WAIT_DATA;
      WAIT_DATA: state_d = ACCUM;
`else
      ACT_RE:    state_d = ACCUM;
`endif
      ACCUM:     state_d = all_max ? DONE : SEND_ADDR;
      DONE: begin
        if (Start) begin
          state_d = SEND_ADDR;
          idx_clr = 1'b1;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters advance on the edge that ends ACCUM.
  assign idx_inc = (state_q == ACCUM);

  dct_index_counter u_cnt (
    .clk     (Clock),
    .rst_n   (Reset),
    .clr     (idx_clr),
    .inc     (idx_inc),
    .idx     (idx),
    .all_max (all_max)
  );

  assign var_u       = idx.u;
  assign var_v       = idx.v;
  assign var_x       = idx.x;
  assign var_y       = idx.y;
  assign Address     = {idx.y, idx.x};
  assign Read_Enable = (state_q == ACT_RE);
  assign Active_MAC  = (state_q == ACCUM);
  assign Ready       = (state_q == DONE);

endmodule

// File: tb/tb_fsm_control.sv
// Self-checking bench for fsm_control: cycle model plus literal checks.
// Honours FSM_CONTROL_WAIT_STATE_EN for the step length.
module tb_fsm_control;

`ifdef FSM_CONTROL_WAIT_STATE_EN
  localparam int P = 4;
`else
  localparam int P = 3;
`endif
  localparam int NMAC = 4096;
  localparam int RUN_EDGES = NMAC * P;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic [2:0] var_u, var_v, var_x, var_y;
  logic [5:0] Address;
  logic       Read_Enable, Active_MAC, Ready;

  fsm_control dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .var_u       (var_u),
    .var_v       (var_v),
    .var_x       (var_x),
    .var_y       (var_y),
    .Address     (Address),
    .Read_Enable (Read_Enable),
    .Active_MAC  (Active_MAC),
    .Ready       (Ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int vectors = 0;
  int errors  = 0;
  int mac_cnt = 0;
  int re_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 running (t cycles into run), 2 done.
  int mode = 0;
  int t = 0;
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mode = 0;
      t = 0;
    end else begin
      case (mode)
        1: begin
          t++;
          if (t == RUN_EDGES) mode = 2;
        end
        default: begin
          if (Start) begin
            mode = 1;
            t = 0;
          end
        end
      endcase
    end
  end

  // Every-cycle compare against the model.
  always @(negedge Clock) begin
    int k, ph;
    logic [2:0] eu, ev, ex, ey;
    logic [5:0] ea;
    logic       ere, emac, erdy;
    k = 0; ph = 0;
    if (mode == 1) begin
      k = t / P;
      ph = t % P;
    end
    ex = 3'(k % 8);
    ey = 3'((k / 8) % 8);
    ev = 3'((k / 64) % 8);
    eu = 3'(k / 512);
    ea = 6'(int'(ey) * 8 + int'(ex));
    ere  = (mode == 1) && (ph == 1);
    emac = (mode == 1) && (ph == P - 1);
    erdy = (mode == 2);
    vectors++;
    if ({Ready, Active_MAC, Read_Enable, var_u, var_v, var_x, var_y, Address}
        !== {erdy, emac, ere, eu, ev, ex, ey, ea}) begin
      errors++;
      $display("FAIL cycle @%0t: got rdy%b mac%b re%b u%0d v%0d x%0d y%0d a%0d expected rdy%b mac%b re%b u%0d v%0d x%0d y%0d a%0d",
               $time, Ready, Active_MAC, Read_Enable, var_u, var_v, var_x,
               var_y, Address, erdy, emac, ere, eu, ev, ex, ey, ea);
    end
  end

  // Pulse counting and hand-computed MAC pulse literals.
  always @(negedge Clock) begin
    if (Read_Enable) re_cnt++;
    if (Active_MAC) begin
      mac_cnt++;
      case (mac_cnt)
        1: chk("mac1_uvxy", {var_u, var_v, var_x, var_y}, {3'd0, 3'd0, 3'd0, 3'd0});
        2: chk("mac2_uvxy", {var_u, var_v, var_x, var_y}, {3'd0, 3'd0, 3'd1, 3'd0});
        9: begin
          chk("mac9_uvxy", {var_u, var_v, var_x, var_y}, {3'd0, 3'd0, 3'd0, 3'd1});
          chk("mac9_addr", Address, 8);
        end
        65: chk("mac65_uvxy", {var_u, var_v, var_x, var_y}, {3'd0, 3'd1, 3'd0, 3'd0});
        4096: begin
          chk("mac4096_uvxy", {var_u, var_v, var_x, var_y}, {3'd7, 3'd7, 3'd7, 3'd7});
          chk("mac4096_addr", Address, 63);
        end
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic pulse_start();
    mac_cnt = 0;
    re_cnt = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_ready_low", Ready, 0);
    chk("start_addr", Address, 0);
    chk("start_uvxy", {var_u, var_v, var_x, var_y}, 0);
  endtask

  task automatic full_run(input bit poke);
    int m;
    pulse_start();
    m = 0;
    while (!Ready && m < 20000) begin
      if (poke && m == 1) begin
        chk("poke_in_act_re", Read_Enable, 1);
        Start = 1'b1;
      end
      if (poke && m == 9) Start = 1'b0;
      tick();
      m++;
    end
    Start = 1'b0;
    chk("ready_edges", m, RUN_EDGES);
    chk("mac_pulses", mac_cnt, NMAC);
    chk("re_pulses", re_cnt, NMAC);
    repeat (5) tick();
    chk("ready_hold", Ready, 1);
    chk("done_addr", Address, 0);
  endtask

  task automatic abort_run();
    int m;
    pulse_start();
    m = 0;
    while (mac_cnt < 100 && m < 20000) begin
      tick();
      m++;
    end
    chk("abort_at_100", mac_cnt, 100);
    Reset = 1'b0;
    #1;
    chk("abort_mac", Active_MAC, 0);
    chk("abort_re", Read_Enable, 0);
    chk("abort_ready", Ready, 0);
    chk("abort_addr", Address, 0);
    chk("abort_uvxy", {var_u, var_v, var_x, var_y}, 0);
    tick();
    Reset = 1'b1;
    repeat (2) tick();
    chk("abort_idle_ready", Ready, 0);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    #2 Reset = 1'b0;
    repeat (2) tick();
    chk("rst_re", Read_Enable, 0);
    chk("rst_mac", Active_MAC, 0);
    chk("rst_ready", Ready, 0);
    chk("rst_addr", Address, 0);
    chk("rst_uvxy", {var_u, var_v, var_x, var_y}, 0);
    Reset = 1'b1;
    repeat (3) tick();
    chk("idle_ready", Ready, 0);
    full_run(1'b1);
    abort_run();
    full_run(1'b0);
    full_run(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
